// File: rtl/vjtag_arb_pkg.sv
// Shared types and constants for the two-requester VJTAG bus arbiter.
// Grant is one-hot so bit 1 doubles as "requester 1 owns the bus".
package vjtag_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RD_REQ,
    RD_RSP
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Wide enough for any data bus we expect; callers cast down to DW.
  localparam int MAX_DW = 64;

  function automatic logic [MAX_DW-1:0] timeout_data();
    return '1;
  endfunction

endpackage

// File: rtl/vjtag_rr_pick2.sv
// Two-way round-robin picker: on contention the requester that was not
// granted last wins; a lone requester always wins.
module vjtag_rr_pick2
  import vjtag_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    pick = GNT_NONE;
    if (req == 2'b11) pick = last ? GNT_M0 : GNT_M1;
    else              pick = req;
  end

endmodule

// File: rtl/vjtag_bus_arb.sv
// Round-robin arbiter sharing one bus slave between the VJTAG host (m0) and a
// second master (m1), with read-response routing and a response timeout.
module vjtag_bus_arb
  import vjtag_arb_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int RSP_TIMEOUT = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_address,
  input  logic          m0_wvalid,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_wready,
  input  logic          m0_rvalid,
  output logic          m0_rready,
  output logic          m0_rrvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic [AW-1:0] m1_address,
  input  logic          m1_wvalid,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_wready,
  input  logic          m1_rvalid,
  output logic          m1_rready,
  output logic          m1_rrvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] s_address,
  output logic          s_wvalid,
  output logic [DW-1:0] s_wdata,
  input  logic          s_wready,
  output logic          s_rvalid,
  input  logic          s_rready,
  input  logic          s_rrvalid,
  input  logic [DW-1:0] s_rdata,
  output logic [1:0]    grant,
  output logic          timeout_err
);

  localparam int TW = $clog2(RSP_TIMEOUT + 1);
  localparam int CW = (TW > 0) ? TW : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((RSP_TIMEOUT > 0) ? RSP_TIMEOUT - 1 : 0);
  localparam logic [DW-1:0] TO_DATA = DW'(timeout_data());

  state_t        state;
  logic          last;
  logic [CW-1:0] cnt;
  logic [1:0]    req;
  logic [1:0]    pick;
  logic          pick_wr;
  logic          timed_out;
  logic          rsp_fire;
  logic [DW-1:0] rsp_data;

  assign req     = {m1_wvalid | m1_rvalid, m0_wvalid | m0_rvalid};
  // A requester asserting both channels gets its write served first.
  assign pick_wr = pick[1] ? m1_wvalid : m0_wvalid;

  vjtag_rr_pick2 u_pick (
    .req  (req),
    .last (last),
    .pick (pick)
  );

  always_comb begin
    s_address = '0;
    s_wdata   = '0;
    s_wvalid  = 1'b0;
    s_rvalid  = 1'b0;
    if (state == WRITE || state == RD_REQ) begin
      s_address = grant[1] ? m1_address : m0_address;
      s_wdata   = grant[1] ? m1_wdata   : m0_wdata;
      s_wvalid  = (state == WRITE)  && (grant[1] ? m1_wvalid : m0_wvalid);
      s_rvalid  = (state == RD_REQ) && (grant[1] ? m1_rvalid : m0_rvalid);
    end
  end

  assign m0_wready = (state == WRITE)  && grant[0] && s_wready;
  assign m1_wready = (state == WRITE)  && grant[1] && s_wready;
  assign m0_rready = (state == RD_REQ) && grant[0] && s_rready;
  assign m1_rready = (state == RD_REQ) && grant[1] && s_rready;

  // A real response on the final wait cycle beats the timeout.
  assign timed_out = (RSP_TIMEOUT > 0) && (state == RD_RSP) && (cnt == TO_LAST) && !s_rrvalid;
  assign rsp_fire  = (state == RD_RSP) && (s_rrvalid || timed_out);
  assign rsp_data  = s_rrvalid ? s_rdata : TO_DATA;

  assign m0_rrvalid  = rsp_fire && grant[0];
  assign m1_rrvalid  = rsp_fire && grant[1];
  assign m0_rdata    = m0_rrvalid ? rsp_data : '0;
  assign m1_rdata    = m1_rrvalid ? rsp_data : '0;
  assign timeout_err = timed_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= GNT_NONE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments only, so every branch sees pre-edge state.
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= pick;
            state <= pick_wr ? WRITE : RD_REQ;
          end
        end
        WRITE: begin
          if (s_wvalid && s_wready) begin
            last  <= grant[1];
            grant <= GNT_NONE;
            state <= IDLE;
          end
        end
        RD_REQ: begin
          if (s_rvalid && s_rready) begin
            cnt   <= '0;
            state <= RD_RSP;
          end
        end
        RD_RSP: begin
          if (rsp_fire) begin
            last  <= grant[1];
            grant <= GNT_NONE;
            state <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vjtag_bus_arb.sv
// Directed bench for vjtag_bus_arb: a short-timeout instance checked against a
// response scoreboard, plus a default-timeout instance for slow-slave routing.
module tb_vjtag_bus_arb;

  localparam int AW = 8;
  localparam int DW = 8;

  typedef struct {
    logic          idx;
    logic [DW-1:0] data;
    logic          to;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [AW-1:0] m0_address = '0, m1_address = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, s_rdata = '0;
  logic m0_wvalid = 1'b0, m0_rvalid = 1'b0, m1_wvalid = 1'b0, m1_rvalid = 1'b0;
  logic s_wready = 1'b0, s_rready = 1'b0, s_rrvalid = 1'b0;

  logic          m0_wready, m0_rready, m0_rrvalid, m1_wready, m1_rready, m1_rrvalid;
  logic [DW-1:0] m0_rdata, m1_rdata, s_wdata;
  logic [AW-1:0] s_address;
  logic          s_wvalid, s_rvalid, timeout_err;
  logic [1:0]    grant;

  logic          l_m0_wready, l_m0_rready, l_m0_rrvalid, l_m1_wready, l_m1_rready, l_m1_rrvalid;
  logic [DW-1:0] l_m0_rdata, l_m1_rdata, l_s_wdata;
  logic [AW-1:0] l_s_address;
  logic          l_s_wvalid, l_s_rvalid, l_timeout_err;
  logic [1:0]    l_grant;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  rsp_t sb[$];

  always #5 clk = ~clk;

  vjtag_bus_arb #(.AW(AW), .DW(DW), .RSP_TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata), .m0_wready(m0_wready),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rrvalid(m0_rrvalid), .m0_rdata(m0_rdata),
    .m1_address(m1_address), .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wready(m1_wready),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rrvalid(m1_rrvalid), .m1_rdata(m1_rdata),
    .s_address(s_address), .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wready(s_wready),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rrvalid(s_rrvalid), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  vjtag_bus_arb #(.AW(AW), .DW(DW)) u_long (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata), .m0_wready(l_m0_wready),
    .m0_rvalid(m0_rvalid), .m0_rready(l_m0_rready), .m0_rrvalid(l_m0_rrvalid), .m0_rdata(l_m0_rdata),
    .m1_address(m1_address), .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wready(l_m1_wready),
    .m1_rvalid(m1_rvalid), .m1_rready(l_m1_rready), .m1_rrvalid(l_m1_rrvalid), .m1_rdata(l_m1_rdata),
    .s_address(l_s_address), .s_wvalid(l_s_wvalid), .s_wdata(l_s_wdata), .s_wready(s_wready),
    .s_rvalid(l_s_rvalid), .s_rready(s_rready), .s_rrvalid(s_rrvalid), .s_rdata(s_rdata),
    .grant(l_grant), .timeout_err(l_timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic idx, input logic [DW-1:0] data, input logic to);
    rsp_t e;
    e.idx  = idx;
    e.data = data;
    e.to   = to;
    sb.push_back(e);
  endtask

  // Every response pulse from the short-timeout instance must match the oldest expectation.
  always @(negedge clk) begin
    if (m0_rrvalid || m1_rrvalid || timeout_err) begin
      rsp_t e;
      check("rsp_pending", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rsp_m0_rrvalid", 32'(m0_rrvalid), 32'(!e.idx));
        check("rsp_m1_rrvalid", 32'(m1_rrvalid), 32'(e.idx));
        check("rsp_rdata", 32'(e.idx ? m1_rdata : m0_rdata), 32'(e.data));
        check("rsp_timeout_err", 32'(timeout_err), 32'(e.to));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_s_outputs", 32'({s_wvalid, s_rvalid, s_address, s_wdata}), 0);
    check("rst_m_outputs", 32'({m0_wready, m1_wready, m0_rready, m1_rready,
                                m0_rrvalid, m1_rrvalid, timeout_err}), 0);
    check("rst_rdata", 32'({m0_rdata, m1_rdata}), 0);
    tick();
    rst = 1'b0;

    // Single write from m0, slave stalls one cycle
    m0_wvalid = 1'b1; m0_address = 8'h10; m0_wdata = 8'hA5;
    @(negedge clk);
    check("wr_bubble", 32'({grant, s_wvalid}), 0);
    tick();
    @(negedge clk);
    check("wr_grant", 32'(grant), 'h1);
    check("wr_s_wvalid", 32'(s_wvalid), 1);
    check("wr_s_address", 32'(s_address), 'h10);
    check("wr_s_wdata", 32'(s_wdata), 'hA5);
    check("wr_wait", 32'(m0_wready), 0);
    tick();
    s_wready = 1'b1;
    @(negedge clk);
    check("wr_m0_wready", 32'(m0_wready), 1);
    check("wr_m1_wready", 32'(m1_wready), 0);
    tick();
    m0_wvalid = 1'b0; s_wready = 1'b0;
    @(negedge clk);
    check("wr_done_grant", 32'(grant), 0);
    check("wr_done_s_wvalid", 32'(s_wvalid), 0);

    // Contention straight out of reset: m0 read vs m1 write
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_wready = 1'b1; s_rready = 1'b1;
    m0_rvalid = 1'b1; m0_address = 8'h20;
    m1_wvalid = 1'b1; m1_address = 8'h30; m1_wdata = 8'h77;
    tick();
    @(negedge clk);
    check("ct_grant_m0", 32'(grant), 'h1);
    check("ct_s_rvalid", 32'(s_rvalid), 1);
    check("ct_s_wvalid", 32'(s_wvalid), 0);
    check("ct_s_address", 32'(s_address), 'h20);
    check("ct_m0_rready", 32'(m0_rready), 1);
    check("ct_m1_wready", 32'(m1_wready), 0);
    tick();
    m0_rvalid = 1'b0;
    s_rrvalid = 1'b1; s_rdata = 8'h42;
    expect_rsp(1'b0, 8'h42, 1'b0);
    @(negedge clk);
    check("ct_rsp_s_rvalid", 32'(s_rvalid), 0);
    tick();
    s_rrvalid = 1'b0;
    @(negedge clk);
    check("ct_bubble", 32'(grant), 0);
    tick();
    @(negedge clk);
    check("ct_grant_m1", 32'(grant), 'h2);
    check("ct_m1_s_address", 32'(s_address), 'h30);
    check("ct_m1_s_wdata", 32'(s_wdata), 'h77);
    check("ct_m1_wready", 32'(m1_wready), 1);
    check("ct_m0_wready", 32'(m0_wready), 0);
    tick();

    // Both keep writing: grants alternate m0, m1, m0
    m0_wvalid = 1'b1; m0_address = 8'h40; m0_wdata = 8'h01;
    m1_wdata  = 8'h02;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("alt_grant", 32'(grant), (i == 1) ? 'h2 : 'h1);
      check("alt_wdata", 32'(s_wdata), (i == 1) ? 'h02 : 'h01);
      tick();
    end
    m0_wvalid = 1'b0; m1_wvalid = 1'b0;

    // Write and read asserted together: write goes first
    s_wready = 1'b0; s_rready = 1'b0;
    m0_wvalid = 1'b1; m0_rvalid = 1'b1; m0_address = 8'h50; m0_wdata = 8'hC3;
    tick();
    @(negedge clk);
    check("wf_s_wvalid", 32'(s_wvalid), 1);
    check("wf_s_rvalid", 32'(s_rvalid), 0);
    check("wf_s_wdata", 32'(s_wdata), 'hC3);
    tick();
    s_wready = 1'b1;
    @(negedge clk);
    check("wf_m0_wready", 32'(m0_wready), 1);
    check("wf_m0_rready", 32'(m0_rready), 0);
    tick();
    m0_wvalid = 1'b0; m0_rvalid = 1'b0; s_rready = 1'b1;
    @(negedge clk);
    check("wf_done_grant", 32'(grant), 0);

    // Read timeout: slave never answers
    m0_rvalid = 1'b1; m0_address = 8'h44;
    tick();
    @(negedge clk);
    check("to_m0_rready", 32'(m0_rready), 1);
    tick();
    m0_rvalid = 1'b0;
    expect_rsp(1'b0, 8'hFF, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("to_early", 32'(m0_rrvalid | timeout_err), 0);
      tick();
    end
    @(negedge clk);
    check("to_fire", 32'({m0_rrvalid, timeout_err}), 'h3);
    tick();
    @(negedge clk);
    check("to_pulse_end", 32'(timeout_err), 0);
    check("to_grant_clear", 32'(grant), 0);
    tick();
    s_rrvalid = 1'b1; s_rdata = 8'h99;
    @(negedge clk);
    check("to_late_dropped", 32'({m0_rrvalid, m1_rrvalid}), 0);
    tick();
    s_rrvalid = 1'b0;

    // Response lands on the exact timeout cycle
    m0_rvalid = 1'b1; m0_address = 8'h45;
    tick();
    tick();
    m0_rvalid = 1'b0;
    repeat (3) tick();
    s_rrvalid = 1'b1; s_rdata = 8'h11;
    expect_rsp(1'b0, 8'h11, 1'b0);
    @(negedge clk);
    check("race_timeout_err", 32'(timeout_err), 0);
    check("race_rdata", 32'(m0_rdata), 'h11);
    tick();
    s_rrvalid = 1'b0;

    // Reset while waiting for a read response
    m0_rvalid = 1'b1; m0_address = 8'h55;
    tick();
    tick();
    m0_rvalid = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_grant", 32'(grant), 0);
    check("mid_rst_outputs", 32'({s_rvalid, s_address, m0_rrvalid}), 0);
    tick();
    rst = 1'b0;
    tick();
    s_rrvalid = 1'b1; s_rdata = 8'h77;
    @(negedge clk);
    check("mid_rst_stray", 32'({m0_rrvalid, m1_rrvalid, timeout_err}), 0);
    check("mid_rst_idle", 32'(grant), 0);
    tick();
    s_rrvalid = 1'b0;

    // m1 read with a slow slave (5 cycles after rready)
    m1_rvalid = 1'b1; m1_address = 8'h3C;
    tick();
    @(negedge clk);
    check("rt_grant", 32'(grant), 'h2);
    check("rt_long_grant", 32'(l_grant), 'h2);
    check("rt_s_address", 32'(s_address), 'h3C);
    check("rt_m1_rready", 32'(m1_rready), 1);
    check("rt_m0_rready", 32'(m0_rready), 0);
    tick();
    m1_rvalid = 1'b0;
    expect_rsp(1'b1, 8'hFF, 1'b1);
    repeat (4) tick();
    s_rrvalid = 1'b1; s_rdata = 8'h5A;
    @(negedge clk);
    check("rt_long_m1_rrvalid", 32'(l_m1_rrvalid), 1);
    check("rt_long_m1_rdata", 32'(l_m1_rdata), 'h5A);
    check("rt_long_m0_quiet", 32'({l_m0_rrvalid, l_m0_rdata}), 0);
    check("rt_long_timeout_err", 32'(l_timeout_err), 0);
    check("rt_short_dropped", 32'(m1_rrvalid), 0);
    tick();
    s_rrvalid = 1'b0;
    tick();
    @(negedge clk);
    check("rt_long_idle", 32'(l_grant), 0);
    check("sb_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
